// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the fetch (IF) and load/store (D) requesters.
// Data requests win by default; a streak counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        CLK,
    input  logic        RESET,

    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_GNT,
    output logic        IF_RVALID,
    output logic [31:0] IF_RDATA,

    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_RVALID,
    output logic [31:0] D_RDATA,

    output logic        ERR,

    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,

    output logic        BUSY
);

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
    localparam logic [7:0] TIMER_MAX  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  timer_q, timer_d;
    logic        owner_is_d_q, owner_is_d_d;

    logic        if_gnt_q, if_gnt_d;
    logic        d_gnt_q, d_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic        err_q, err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        busy_q, busy_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        d_wins;
    logic        if_wins;

    // Fetch only overrides data once the streak has hit its limit with fetch waiting.
    assign d_wins  = D_REQ && !(IF_REQ && (streak_q == STREAK_MAX));
    assign if_wins = IF_REQ && !d_wins;

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        timer_d      = timer_q;
        owner_is_d_d = owner_is_d_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        err_d        = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (d_wins) begin
                    state_d      = ISSUE;
                    d_gnt_d      = 1'b1;
                    mem_req_d    = 1'b1;
                    owner_is_d_d = 1'b1;
                    mem_we_d     = D_WE;
                    mem_addr_d   = D_ADDR;
                    mem_wdata_d  = D_WDATA;
                    // d_wins with fetch pending implies the streak is still below its limit.
                    if (IF_REQ) begin
                        streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (if_wins) begin
                    state_d      = ISSUE;
                    if_gnt_d     = 1'b1;
                    mem_req_d    = 1'b1;
                    owner_is_d_d = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = IF_ADDR;
                    mem_wdata_d  = 32'd0;
                    streak_d     = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                state_d = WAIT;
                timer_d = 8'd1;
            end

            WAIT: begin
                if (MEM_RVALID || (timer_q == TIMER_MAX)) begin
                    state_d     = RESP;
                    err_d       = !MEM_RVALID;
                    if_rvalid_d = !owner_is_d_q;
                    d_rvalid_d  = owner_is_d_q;
                    // Writes only get an ack; the owner's read data register is left alone.
                    if (!mem_we_q) begin
                        if (owner_is_d_q) begin
                            d_rdata_d = MEM_RVALID ? MEM_RDATA : 32'd0;
                        end else begin
                            if_rdata_d = MEM_RVALID ? MEM_RDATA : 32'd0;
                        end
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            streak_q     <= 4'd0;
            timer_q      <= 8'd0;
            owner_is_d_q <= 1'b0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            timer_q      <= timer_d;
            owner_is_d_q <= owner_is_d_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign IF_GNT    = if_gnt_q;
    assign IF_RVALID = if_rvalid_q;
    assign IF_RDATA  = if_rdata_q;
    assign D_GNT     = d_gnt_q;
    assign D_RVALID  = d_rvalid_q;
    assign D_RDATA   = d_rdata_q;
    assign ERR       = err_q;
    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign BUSY      = busy_q;

    // The two grants are mutually exclusive and a grant always comes with a memory request.
    a_gnt_exclusive: assert property (@(posedge CLK) disable iff (RESET) !(if_gnt_q && d_gnt_q));
    a_gnt_with_req:  assert property (@(posedge CLK) disable iff (RESET) (if_gnt_q || d_gnt_q) == mem_req_q);
    a_rvalid_excl:   assert property (@(posedge CLK) disable iff (RESET) !(if_rvalid_q && d_rvalid_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory traffic and responses; the bench also plays both requesters and the memory.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_GNT;
    logic        IF_RVALID;
    logic [31:0] IF_RDATA;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic        D_GNT;
    logic        D_RVALID;
    logic [31:0] D_RDATA;
    logic        ERR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;
    logic        BUSY;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IF_REQ    (IF_REQ),
        .IF_ADDR   (IF_ADDR),
        .IF_GNT    (IF_GNT),
        .IF_RVALID (IF_RVALID),
        .IF_RDATA  (IF_RDATA),
        .D_REQ     (D_REQ),
        .D_WE      (D_WE),
        .D_ADDR    (D_ADDR),
        .D_WDATA   (D_WDATA),
        .D_GNT     (D_GNT),
        .D_RVALID  (D_RVALID),
        .D_RDATA   (D_RDATA),
        .ERR       (ERR),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RVALID(MEM_RVALID),
        .MEM_RDATA (MEM_RDATA),
        .BUSY      (BUSY)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pending requests, starvation streak and the last data each requester saw.
    bit          if_pend;
    bit          d_pend;
    bit          d_we_m;
    bit          auto_raise;
    logic [31:0] if_addr_m;
    logic [31:0] d_addr_m;
    logic [31:0] d_wdata_m;
    logic [31:0] if_rdata_m;
    logic [31:0] d_rdata_m;
    int          streak_m;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_flags(input string ph, input bit if_gnt, input bit d_gnt, input bit mem_req,
                                input bit if_rv, input bit d_rv, input bit err, input bit busy);
        checkOutput({ph, "_if_gnt"},    32'(IF_GNT),    32'(if_gnt));
        checkOutput({ph, "_d_gnt"},     32'(D_GNT),     32'(d_gnt));
        checkOutput({ph, "_mem_req"},   32'(MEM_REQ),   32'(mem_req));
        checkOutput({ph, "_if_rvalid"}, 32'(IF_RVALID), 32'(if_rv));
        checkOutput({ph, "_d_rvalid"},  32'(D_RVALID),  32'(d_rv));
        checkOutput({ph, "_err"},       32'(ERR),       32'(err));
        checkOutput({ph, "_busy"},      32'(BUSY),      32'(busy));
    endtask

    task automatic check_all_zero(input string ph);
        expect_flags(ph, 0, 0, 0, 0, 0, 0, 0);
        checkOutput({ph, "_mem_we"},    32'(MEM_WE), 32'd0);
        checkOutput({ph, "_mem_addr"},  MEM_ADDR,    32'd0);
        checkOutput({ph, "_mem_wdata"}, MEM_WDATA,   32'd0);
        checkOutput({ph, "_if_rdata"},  IF_RDATA,    32'd0);
        checkOutput({ph, "_d_rdata"},   D_RDATA,     32'd0);
    endtask

    task automatic raise_if(input logic [31:0] addr);
        if_pend   = 1'b1;
        if_addr_m = addr;
        IF_REQ    = 1'b1;
        IF_ADDR   = addr;
    endtask

    task automatic raise_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        d_pend    = 1'b1;
        d_we_m    = we;
        d_addr_m  = addr;
        d_wdata_m = wdata;
        D_REQ     = 1'b1;
        D_WE      = we;
        D_ADDR    = addr;
        D_WDATA   = wdata;
    endtask

    // Requesters raise new work at random whenever they have nothing pending.
    task automatic applyStimulus();
        if (!auto_raise) return;
        if (!if_pend && ($urandom_range(0, 2) != 0))
            raise_if($urandom & 32'hFFFF_FFFC);
        if (!d_pend && ($urandom_range(0, 3) != 0))
            raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    // Called in an IDLE or RESP cycle with this cycle's requests on the pins.
    // lat = WAIT cycle in which memory answers; lat > TIMEOUT means it never does.
    task automatic run_round(input int lat, input logic [31:0] data);
        bit          pick_d;
        bit          is_write;
        bit          timed_out;
        int          w;
        logic [31:0] exp_addr;

        if (!if_pend && !d_pend) begin
            MEM_RVALID = 1'($urandom_range(0, 1));
            MEM_RDATA  = $urandom;
            step();
            MEM_RVALID = 1'b0;
            expect_flags("idle", 0, 0, 0, 0, 0, 0, 0);
            applyStimulus();
            return;
        end

        pick_d = d_pend && !(if_pend && streak_m == STARVE_MAX);
        if (pick_d)
            streak_m = if_pend ? ((streak_m < STARVE_MAX) ? streak_m + 1 : STARVE_MAX) : 0;
        else
            streak_m = 0;
        is_write = pick_d && d_we_m;
        exp_addr = pick_d ? d_addr_m : if_addr_m;

        step();
        expect_flags("issue", !pick_d, pick_d, 1, 0, 0, 0, 1);
        checkOutput("issue_addr", MEM_ADDR, exp_addr);
        checkOutput("issue_we", 32'(MEM_WE), 32'(is_write));
        if (is_write) checkOutput("issue_wdata", MEM_WDATA, d_wdata_m);

        if (pick_d) begin
            d_pend = 1'b0;
            D_REQ  = 1'b0;
        end else begin
            if_pend = 1'b0;
            IF_REQ  = 1'b0;
        end
        MEM_RVALID = 1'($urandom_range(0, 1));
        MEM_RDATA  = $urandom;

        w = 0;
        do begin
            step();
            w++;
            expect_flags("wait", 0, 0, 0, 0, 0, 0, 1);
            checkOutput("wait_addr", MEM_ADDR, exp_addr);
            applyStimulus();
            MEM_RVALID = (w == lat);
            MEM_RDATA  = (w == lat) ? data : $urandom;
        end while (!(w == lat || w == TIMEOUT));

        step();
        MEM_RVALID = 1'($urandom_range(0, 1));
        MEM_RDATA  = $urandom;
        timed_out  = (lat > TIMEOUT);
        if (!is_write) begin
            if (pick_d) d_rdata_m  = timed_out ? 32'd0 : data;
            else        if_rdata_m = timed_out ? 32'd0 : data;
        end
        expect_flags("resp", 0, 0, 0, !pick_d, pick_d, timed_out, 1);
        checkOutput("resp_addr", MEM_ADDR, exp_addr);
        checkOutput("resp_we", 32'(MEM_WE), 32'(is_write));
        checkOutput("resp_if_rdata", IF_RDATA, if_rdata_m);
        checkOutput("resp_d_rdata", D_RDATA, d_rdata_m);
        applyStimulus();
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int r;
        int lat;

        RESET      = 1'b1;
        IF_REQ     = 1'b0;
        IF_ADDR    = 32'd0;
        D_REQ      = 1'b0;
        D_WE       = 1'b0;
        D_ADDR     = 32'd0;
        D_WDATA    = 32'd0;
        MEM_RVALID = 1'b0;
        MEM_RDATA  = 32'd0;
        if_pend    = 1'b0;
        d_pend     = 1'b0;
        d_we_m     = 1'b0;
        auto_raise = 1'b0;
        if_addr_m  = 32'd0;
        d_addr_m   = 32'd0;
        d_wdata_m  = 32'd0;
        if_rdata_m = 32'd0;
        d_rdata_m  = 32'd0;
        streak_m   = 0;

        step();
        step();
        check_all_zero("reset");
        RESET = 1'b0;

        $display("[TB] single fetch");
        raise_if(32'h100);
        run_round(2, 32'h0050_0093);
        checkOutput("fetch_rdata", IF_RDATA, 32'h0050_0093);
        run_round(1, 32'd0);

        $display("[TB] simultaneous requests");
        raise_if(32'h104);
        raise_d(1'b0, 32'h2000, 32'd0);
        run_round(1, $urandom);
        run_round(3, $urandom);
        run_round(1, 32'd0);

        $display("[TB] fetch starvation guard");
        raise_if(32'h108);
        for (int i = 0; i < 6; i++) begin
            if (!d_pend) raise_d(1'b0, 32'h3000 + 32'(i * 4), 32'd0);
            run_round(1, $urandom);
        end
        run_round(1, 32'd0);

        $display("[TB] store keeps load data");
        raise_d(1'b0, 32'h2000, 32'd0);
        run_round(1, 32'h1234);
        raise_d(1'b1, 32'h2000, 32'hDEAD_BEEF);
        run_round(2, $urandom);
        checkOutput("store_keeps_rdata", D_RDATA, 32'h1234);
        run_round(1, 32'd0);

        $display("[TB] load timeout");
        raise_d(1'b0, 32'h2004, 32'd0);
        run_round(TIMEOUT + 1, 32'd0);
        run_round(1, 32'd0);

        $display("[TB] reset during wait");
        raise_if(32'h300);
        step();
        expect_flags("rst_issue", 1, 0, 1, 0, 0, 0, 1);
        IF_REQ  = 1'b0;
        if_pend = 1'b0;
        step();
        step();
        RESET = 1'b1;
        #1;
        check_all_zero("rst_async");
        #2;
        RESET      = 1'b0;
        streak_m   = 0;
        if_rdata_m = 32'd0;
        d_rdata_m  = 32'd0;
        step();
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'hCAFE_F00D;
        step();
        MEM_RVALID = 1'b0;
        check_all_zero("rst_after");
        step();
        check_all_zero("rst_idle");
        raise_if(32'h400);
        run_round(3, 32'h1111_2222);
        run_round(1, 32'd0);

        $display("[TB] random traffic");
        auto_raise = 1'b1;
        applyStimulus();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      lat = TIMEOUT + 1;
            else if (r == 1) lat = TIMEOUT;
            else             lat = $urandom_range(1, 4);
            run_round(lat, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
